hk_passthru_ctrl: RTL
=====================

# hk_passthru_ctrl

Housekeeping-side controller for SPI pass-thru mode. It sits directly downstream of the housekeeping SPI pins (mprj_io[4:1]) and upstream of the management flash pins. It oversamples the external housekeeping SPI in the core clock domain and decodes the first command byte of each transaction. On the pass-thru command it holds the management CPU in reset and bridges SCK/SDI/SDO straight to the flash. When CSB rises it returns flash ownership and releases the CPU so it reboots from flash.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on hk_csb/hk_sck/hk_sdi (min 2).
- PASS_CMD, 8'hC4: command byte selecting management-flash pass-thru.
- RELEASE_CYCLES, 16: clock cycles cpu_reset_hold stays high after CSB rises; legal range 1..255.

Ports:
- clock  in  1  core clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- hk_csb  in  1  housekeeping SPI chip select, asynchronous, active low.
- hk_sck  in  1  housekeeping SPI clock, asynchronous.
- hk_sdi  in  1  housekeeping SPI data in, asynchronous.
- hk_sdo  out  1  data to host; in PASS it equals flash_io1, otherwise 0.
- hk_sdo_oe  out  1  high only in PASS.
- flash_io1  in  1  flash serial data out.
- flash_csb  out  1  flash chip select; low only in PASS.
- flash_clk  out  1  flash clock in PASS, otherwise 0.
- flash_io0  out  1  flash serial data in PASS, otherwise 0.
- cpu_reset_hold  out  1  holds the management CPU in reset.
- pass_active  out  1  high in PASS; muxes flash pins away from the SPI master.

## Operation
- Inputs pass through SYNC_STAGES flops, giving synced signals s_csb, s_sck, s_sdi. One further flop of s_sck forms the rise and fall strobes.
- FSM states: IDLE, CMD, PASS, IGNORE, RELEASE.
- IDLE to CMD: s_csb low. The 3-bit bit counter and the 8-bit shift register clear.
- CMD:
  - On each s_sck rise, shift s_sdi in MSB-first and increment the counter.
  - After the 8th bit, compare with PASS_CMD. Equal goes to PASS; anything else goes to IGNORE.
  - s_csb high before the 8th bit returns to IDLE, with no outputs changed.
- PASS:
  - Outputs: pass_active=1, cpu_reset_hold=1, flash_csb=0, hk_sdo_oe=1.
  - flash_clk is gated to 0 until the first s_sck fall after entry. After that, flash_clk=s_sck and flash_io0=s_sdi.
  - hk_sdo = flash_io1, combinational and unregistered.
  - s_csb high goes to RELEASE.
- IGNORE: all outputs stay at idle values; the normal housekeeping SPI slave handles the command. s_csb high returns to IDLE.
- RELEASE:
  - flash_csb=1, pass_active=0, flash_clk=0, flash_io0=0, hk_sdo_oe=0.
  - cpu_reset_hold stays 1 for RELEASE_CYCLES cycles (8-bit down counter), then the FSM returns to IDLE.
  - s_csb falling during RELEASE is ignored until the FSM reaches IDLE.
- Simultaneous s_csb rise and an s_sck edge: CSB wins and the edge is dropped.

## Timing
- Reset values: flash_csb=1; flash_clk, flash_io0, hk_sdo, hk_sdo_oe, cpu_reset_hold and pass_active all 0; FSM in IDLE.
- Reset mid-PASS forces the reset values in the next cycle.
- Pin-to-strobe latency is SYNC_STAGES+1 cycles.
- PASS entry: the outputs change 1 cycle after the rise strobe of the 8th bit.
- PASS exit: flash_csb rises 1 cycle after s_csb goes high.
- cpu_reset_hold falls exactly RELEASE_CYCLES cycles after flash_csb rises.
- External SCK period must be at least 8 clock periods. SDI must be stable for at least SYNC_STAGES+2 cycles around the SCK rise.

## Structure
- Shared package hk_pkg holds:
  - the FSM state enum;
  - HK_CMD_PASSTHRU_MGMT = 8'hC4;
  - HK_CMD_PASSTHRU_USER = 8'hC2, reserved for the future user-flash variant.
- One sub-module, hk_sync_edge: an N-stage synchronizer plus rise/fall strobe generator, instantiated once per input (three instances).

## Test plan
- Reset asserted during PASS: outputs return to reset values within 1 cycle; FSM is in IDLE.
- CSB low, byte 0x40 then 0x03, CSB high: FSM passes through IGNORE; flash_csb stays 1, cpu_reset_hold stays 0, hk_sdo_oe stays 0 throughout.
- Byte 0xC4 at SCK period 10 clocks:
  - flash_csb falls and cpu_reset_hold rises 4 cycles after the 8th SCK rise (SYNC_STAGES+1 synchronizer/strobe cycles, plus 1 from the PASS-entry rule);
  - the first flash_clk pulse lines up with the 9th SCK.
- Byte 0xC4, 0x03, 0x00, 0x00, 0x00, then 8 bytes read against the flash model loaded with 93 00 00 00 93 01 00 00: hk_sdo returns exactly those bytes.
- CSB rise after a PASS transaction: flash_csb=1 after 1 cycle; cpu_reset_hold falls exactly 16 cycles later.
- CSB high after 5 bits of 0xC4: FSM back in IDLE, no pass-thru entry; a following complete 0xC4 command then enters PASS normally.

Source files
------------

// File: rtl/hk_pkg.sv
// Shared housekeeping SPI definitions: controller state encoding and command bytes.
// Pure declarations; no logic, latency or flow control of its own.
package hk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_PASS    = 3'd2,
    ST_IGNORE  = 3'd3,
    ST_RELEASE = 3'd4
  } hk_state_t;

  localparam logic [7:0] HK_CMD_PASSTHRU_MGMT = 8'hC4;
  // Reserved for the user-area flash variant of pass-thru.
  localparam logic [7:0] HK_CMD_PASSTHRU_USER = 8'hC2;

  function automatic logic [7:0] shift_in_msb(input logic [7:0] sr, input logic b);
    return {sr[6:0], b};
  endfunction

endpackage

// File: rtl/hk_sync_edge.sv
// N-stage synchronizer with registered rise/fall strobes for one asynchronous pin.
// sync_out lags the pin by STAGES cycles, strobes by STAGES+1; no backpressure.
module hk_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      dly   <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      dly   <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~dly;
      fall  <= ~chain[STAGES-1] & dly;
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/hk_passthru_ctrl.sv
// Decodes the first housekeeping SPI byte and, on the pass-thru command, bridges SPI to the
// management flash while holding the CPU in reset; entry 1 cycle after the 8th-bit strobe, no backpressure.
module hk_passthru_ctrl
  import hk_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [7:0] PASS_CMD       = HK_CMD_PASSTHRU_MGMT,
  parameter int         RELEASE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic hk_csb,
  input  logic hk_sck,
  input  logic hk_sdi,
  output logic hk_sdo,
  output logic hk_sdo_oe,
  input  logic flash_io1,
  output logic flash_csb,
  output logic flash_clk,
  output logic flash_io0,
  output logic cpu_reset_hold,
  output logic pass_active
);

  localparam logic [7:0] REL_LOAD = 8'(RELEASE_CYCLES - 1);

  logic s_csb, s_sck, s_sdi;
  logic sck_rise, sck_fall;
  logic unused_csb_rise, unused_csb_fall, unused_sdi_rise, unused_sdi_fall;

  hk_state_t  state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic [7:0] rel_cnt, rel_cnt_nxt;
  logic       clk_en, clk_en_nxt;
  logic       in_pass;

  hk_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
    .clock    (clock),
    .reset    (reset),
    .async_in (hk_csb),
    .sync_out (s_csb),
    .rise     (unused_csb_rise),
    .fall     (unused_csb_fall)
  );

  hk_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clock    (clock),
    .reset    (reset),
    .async_in (hk_sck),
    .sync_out (s_sck),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  hk_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clock    (clock),
    .reset    (reset),
    .async_in (hk_sdi),
    .sync_out (s_sdi),
    .rise     (unused_sdi_rise),
    .fall     (unused_sdi_fall)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      rel_cnt <= '0;
      clk_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift_q <= shift_nxt;
      rel_cnt <= rel_cnt_nxt;
      clk_en  <= clk_en_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    rel_cnt_nxt = rel_cnt;
    clk_en_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!s_csb) begin
          state_nxt   = ST_CMD;
          bit_cnt_nxt = '0;
          shift_nxt   = '0;
        end
      end
      ST_CMD: begin
        // CSB is checked first so a coincident SCK edge is dropped.
        if (s_csb) begin
          state_nxt = ST_IDLE;
        end else if (sck_rise) begin
          shift_nxt   = shift_in_msb(shift_q, s_sdi);
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = (shift_in_msb(shift_q, s_sdi) == PASS_CMD) ? ST_PASS : ST_IGNORE;
          end
        end
      end
      ST_PASS: begin
        if (s_csb) begin
          state_nxt   = ST_RELEASE;
          rel_cnt_nxt = REL_LOAD;
        end else begin
          // SCK is still high from the command byte on entry; open the gate only after it falls.
          clk_en_nxt = clk_en | sck_fall;
        end
      end
      ST_IGNORE: begin
        if (s_csb) state_nxt = ST_IDLE;
      end
      ST_RELEASE: begin
        if (rel_cnt == 8'd0) state_nxt = ST_IDLE;
        else                 rel_cnt_nxt = rel_cnt - 8'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_pass        = (state == ST_PASS);
    pass_active    = in_pass;
    flash_csb      = ~in_pass;
    hk_sdo_oe      = in_pass;
    hk_sdo         = in_pass & flash_io1;
    flash_clk      = in_pass & clk_en & s_sck;
    flash_io0      = in_pass & clk_en & s_sdi;
    cpu_reset_hold = in_pass | (state == ST_RELEASE);
  end

endmodule
